fft_input_framer: RTL and testbench

FFT_INPUT_FRAMER -- requirements
Module: fft_input_framer

---
 rtl/fft_input_framer.sv | 190 +++++++++++++++++++
 tb/tb_fft_input_framer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// Ping-pong framer that collects a stream of I/Q samples into fixed-length frames
// and replays each full frame back-to-back with FFT control sideband.
package fft_pkg;
    localparam int FFT_INDEX_W = 6;
    localparam int FFT_TAG_W   = 8;

    typedef struct packed {
        logic                   valid;
        logic                   last;
        logic                   reverse;
        logic [FFT_INDEX_W-1:0] data_index;
        logic [FFT_TAG_W-1:0]   tag;
    } fft_control_t;
endpackage

module fft_input_framer
    import fft_pkg::*;
#(
    parameter int NUM_POINTS  = 32,
    parameter int INDEX_WIDTH = $clog2(NUM_POINTS),
    parameter int DATA_WIDTH  = 16,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Input_valid,
    input  logic signed [DATA_WIDTH-1:0] Input_i,
    input  logic signed [DATA_WIDTH-1:0] Input_q,
    input  logic                         Frame_sync,
    input  logic                         Reverse,
    output fft_control_t                 Output_control,
    output logic signed [DATA_WIDTH-1:0] Output_i,
    output logic signed [DATA_WIDTH-1:0] Output_q,
    output logic                         Status_discard
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_POINTS - 1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    // Write side
    logic [INDEX_WIDTH-1:0] write_count_q, write_count_d;
    logic                   wr_bank_q, wr_bank_d;
    logic [1:0]             full_q, full_d;
    logic [1:0]             rev_q, rev_d;
    logic                   discard_q, discard_d;
    logic [INDEX_WIDTH-1:0] wr_index;
    logic                   frame_done;

    // Read side
    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] read_count_q, read_count_d;
    logic                   rd_bank_q, rd_bank_d;
    logic                   read_last;
    logic                   issue;
    logic                   release_bank;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    fft_control_t           ctrl_q, ctrl_d;

    logic [2*DATA_WIDTH-1:0] sample_mem [2*NUM_POINTS];
    logic [2*DATA_WIDTH-1:0] rd_data_q;

    // A sync on a partially filled frame restarts the same bank at index 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        write_count_d = write_count_q;
        wr_bank_d     = wr_bank_q;
        rev_d         = rev_q;
        discard_d     = 1'b0;
        wr_index      = Frame_sync ? '0 : write_count_q;
        frame_done    = 1'b0;
        if (Input_valid) begin
            discard_d = Frame_sync && (write_count_q != '0);
            if (wr_index == '0) begin
                rev_d[wr_bank_q] = Reverse;
            end
            if (wr_index == LAST_IDX) begin
                frame_done    = 1'b1;
                write_count_d = '0;
                wr_bank_d     = ~wr_bank_q;
            end else begin
                write_count_d = wr_index + 1'b1;
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (frame_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Rst) begin
            write_count_q <= '0;
            wr_bank_q     <= 1'b0;
            full_q        <= '0;
            rev_q         <= '0;
            discard_q     <= 1'b0;
        end else begin
            write_count_q <= write_count_d;
            wr_bank_q     <= wr_bank_d;
            full_q        <= full_d;
            rev_q         <= rev_d;
            discard_q     <= discard_d;
        end
    end

    // NOTE: the sample store has no reset; its contents are only read after a bank is marked full.
    always_ff @(posedge Clk) begin
        if (Input_valid && !Rst) begin
            sample_mem[{wr_bank_q, wr_index}] <= {Input_i, Input_q};
        end
        rd_data_q <= sample_mem[{rd_bank_q, read_count_q}];
    end

    // Read FSM: state register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state. Chaining straight into the other bank keeps bursts gap-free.
    assign read_last = (read_count_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (full_q[rd_bank_q]) state_d = S_READ;
            S_READ: if (read_last && !full_q[~rd_bank_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        issue        = (state_q == S_READ);
        release_bank = issue && read_last;
        read_count_d = '0;
        if (issue && !read_last) begin
            read_count_d = read_count_q + 1'b1;
        end
        rd_bank_d = release_bank ? ~rd_bank_q : rd_bank_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            read_count_q <= '0;
            rd_bank_q    <= 1'b0;
        end else begin
            read_count_q <= read_count_d;
            rd_bank_q    <= rd_bank_d;
        end
    end

    // Control is registered alongside the memory read so both line up with the data.
    always_comb begin
        ctrl_d            = '0;
        ctrl_d.valid      = issue;
        ctrl_d.last       = issue && read_last;
        ctrl_d.reverse    = rev_q[rd_bank_q];
        ctrl_d.data_index = FFT_INDEX_W'(read_count_q);
        ctrl_d.tag        = FFT_TAG_W'(tag_q);
        tag_d             = release_bank ? tag_q + 1'b1 : tag_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ctrl_q <= '0;
            tag_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            tag_q  <= tag_d;
        end
    end

    assign Output_control = ctrl_q;
    assign Output_i       = rd_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign Output_q       = rd_data_q[DATA_WIDTH-1:0];
    assign Status_discard = discard_q;

endmodule

// File: tb/tb_fft_input_framer.sv
// Scoreboard bench for fft_input_framer: the stimulus side predicts each framed
// output (content, cycle, tag) and discard pulses; a negedge monitor compares them.
module tb_fft_input_framer;
    import fft_pkg::*;

    localparam int N        = 32;
    localparam int DW       = 16;
    localparam int CLK_HALF = 5;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b1;
    logic                 Input_valid = 1'b0;
    logic signed [DW-1:0] Input_i = '0;
    logic signed [DW-1:0] Input_q = '0;
    logic                 Frame_sync = 1'b0;
    logic                 Reverse = 1'b0;
    fft_control_t         Output_control;
    logic signed [DW-1:0] Output_i;
    logic signed [DW-1:0] Output_q;
    logic                 Status_discard;

    fft_input_framer #(
        .NUM_POINTS(N),
        .DATA_WIDTH(DW),
        .TAG_WIDTH (8)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Input_valid   (Input_valid),
        .Input_i       (Input_i),
        .Input_q       (Input_q),
        .Frame_sync    (Frame_sync),
        .Reverse       (Reverse),
        .Output_control(Output_control),
        .Output_i      (Output_i),
        .Output_q      (Output_q),
        .Status_discard(Status_discard)
    );

    always #CLK_HALF Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct {
        int                   idx;
        bit                   last;
        bit                   rev;
        int                   tag;
        logic signed [DW-1:0] si;
        logic signed [DW-1:0] sq;
        int                   at;
    } exp_t;

    exp_t exp_q[$];
    int   disc_q[$];

    // Reference model state
    int                   wc_m = 0;
    int                   tag_m = 0;
    int                   pending = 0;
    bit                   rev_m = 1'b0;
    logic signed [DW-1:0] fb_i [N];
    logic signed [DW-1:0] fb_q [N];
    int                   n = 0;

    task automatic model_accept(input logic signed [DW-1:0] si, input logic signed [DW-1:0] sq,
                                input bit sync, input bit rev, input int acc);
        exp_t e;
        if (sync && wc_m != 0) disc_q.push_back(acc);
        if (sync) wc_m = 0;
        if (wc_m == 0) rev_m = rev;
        fb_i[wc_m] = si;
        fb_q[wc_m] = sq;
        if (wc_m == N - 1) begin
            // Only one other frame may still be buffered when this one completes.
            check("frames_buffered_le2", (pending < 2), 1);
            for (int j = 0; j < N; j++) begin
                e.idx  = j;
                e.last = (j == N - 1);
                e.rev  = rev_m;
                e.tag  = tag_m % 256;
                e.si   = fb_i[j];
                e.sq   = fb_q[j];
                e.at   = acc + 2 + j;
                exp_q.push_back(e);
            end
            tag_m++;
            pending++;
            wc_m = 0;
        end else begin
            wc_m++;
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        disc_q.delete();
        wc_m    = 0;
        tag_m   = 0;
        pending = 0;
    endtask

    // Gap cycles drive Frame_sync high with Input_valid low; the DUT must ignore them.
    task automatic send(input int si, input int sq, input bit sync, input bit rev, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge Clk);
            Input_valid = 1'b0;
            Frame_sync  = 1'b1;
            Reverse     = ~rev;
            Input_i     = '1;
        end
        @(negedge Clk);
        Input_valid = 1'b1;
        Input_i     = DW'(si);
        Input_q     = DW'(sq);
        Frame_sync  = sync;
        Reverse     = rev;
        model_accept(DW'(si), DW'(sq), sync, rev, cyc + 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge Clk);
        Input_valid = 1'b0;
        Frame_sync  = 1'b0;
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge Clk);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor
    exp_t mon_e;
    bit   want_disc;
    always @(negedge Clk) begin
        if (!Rst) begin
            want_disc = (disc_q.size() > 0) && (disc_q[0] == cyc);
            check("status_discard", Status_discard, want_disc);
            if (want_disc) void'(disc_q.pop_front());
            if (Output_control.valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", Output_control.valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_cycle", cyc, mon_e.at);
                    check("data_index", Output_control.data_index, mon_e.idx);
                    check("last", Output_control.last, mon_e.last);
                    check("reverse", Output_control.reverse, mon_e.rev);
                    check("tag", Output_control.tag, mon_e.tag);
                    check("out_i", Output_i, mon_e.si);
                    check("out_q", Output_q, mon_e.sq);
                    if (mon_e.last) pending--;
                end
            end
        end
    end

    initial begin
        #(2 * CLK_HALF * 50000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    bit found;

    initial begin
        // Reset with junk inputs present
        Rst         = 1'b1;
        Input_valid = 1'b1;
        Frame_sync  = 1'b1;
        Input_i     = 16'sh1234;
        Input_q     = -16'sh0123;
        repeat (3) @(negedge Clk);
        check("reset_valid", Output_control.valid, 0);
        check("reset_discard", Status_discard, 0);
        Rst         = 1'b0;
        Input_valid = 1'b0;
        Frame_sync  = 1'b0;

        // Continuous ramp, three frames back-to-back
        for (int k = 0; k < 3 * N; k++) begin send(n, -n, 1'b0, 1'b0, 0); n++; end

        // Gaps of 0..5 cycles between samples
        for (int k = 0; k < 2 * N; k++) begin send(n, -n, 1'b0, 1'b0, (k * 7 + 3) % 6); n++; end

        // Sync at write_count 10: discard pulse, sync sample becomes index 0
        for (int k = 0; k < 10; k++) begin send(n, -n, 1'b0, 1'b0, 0); n++; end
        for (int k = 0; k < N; k++) begin send(n, -n, (k == 0), 1'b0, 0); n++; end

        // Sync at write_count 0: plain index-0 write, no pulse
        for (int k = 0; k < N; k++) begin send(n, -n, (k == 0), 1'b0, 1); n++; end

        // Reverse toggled at index 5 in both directions
        for (int k = 0; k < N; k++) begin send(n, -n, 1'b0, (k < 5), 0); n++; end
        for (int k = 0; k < N; k++) begin send(n, -n, 1'b0, (k >= 5), 0); n++; end

        // Run up to 257 frames so the tag wraps 255 -> 0
        while (tag_m < 257) begin
            for (int k = 0; k < N; k++) begin send(n, -n, 1'b0, tag_m[0], 0); n++; end
        end
        drain();

        // Reset while index 12 of a burst is on the output
        for (int k = 0; k < N + 8; k++) begin send(n, -n, 1'b0, 1'b0, 0); n++; end
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge Clk);
            Input_valid = 1'b0;
            Frame_sync  = 1'b0;
            if (Output_control.valid && Output_control.data_index == 12) found = 1'b1;
        end
        check("reset_idx12_seen", found, 1);
        Rst         = 1'b1;
        Input_valid = 1'b1;
        Frame_sync  = 1'b1;
        Input_i     = 16'sh5555;
        @(negedge Clk);
        check("valid_after_reset", Output_control.valid, 0);
        flush_model();
        repeat (2) @(negedge Clk);
        Rst         = 1'b0;
        Input_valid = 1'b0;
        Frame_sync  = 1'b0;

        // First post-reset frame: tag 0, full-scale values pass bit-exact
        for (int k = 0; k < N; k++) begin send(32767 - k, -32768 + k, 1'b0, 1'b1, 0); end
        drain();

        repeat (5) @(negedge Clk);
        check("discard_queue_empty", disc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
